// File: rtl/cam_capture.sv
// Camera front-end: generates xclk, synchronises the sensor bus into clk, assembles
// multi-byte pixels and produces decimated, linearly addressed SRAM writes per frame.
module cam_capture #(
  parameter int DW         = 8,
  parameter int BPP        = 2,
  parameter int XW         = 10,
  parameter int YW         = 9,
  parameter int AW         = 12,
  parameter int XCLK_DIV   = 4,
  parameter int DEC_LOG2   = 0,
  parameter int CONTINUOUS = 0
) (
  input  logic              clk,
  input  logic              res,
  input  logic              capture,
  input  logic              apclk,
  input  logic              ahref,
  input  logic              avsync,
  input  logic [DW-1:0]     adata,
  output logic              xclk,
  output logic              wr_en,
  output logic [DW*BPP-1:0] wr_data,
  output logic [AW-1:0]     wr_addr,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy
);

  localparam int PW = DW * BPP;
  localparam int CW = (XCLK_DIV > 1) ? $clog2(XCLK_DIV) : 1;
  localparam int BW = (BPP > 1) ? $clog2(BPP) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

  state_t          state_reg, state_next;
  logic            frame_start_next, frame_done_next;
  logic [CW-1:0]   div_cnt_reg;
  logic [2:0]      pclk_sync_reg, href_sync_reg, vsync_sync_reg;
  logic [DW-1:0]   data_s1_reg, data_s2_reg;
  logic [PW-1:0]   pix_reg, pix_shift;
  logic [BW-1:0]   byte_cnt_reg;
  logic [XW-1:0]   x_reg;
  logic [YW-1:0]   y_reg;
  logic [AW-1:0]   addr_reg;
  logic            line_pix_reg;
  logic            pclk_rise, href_s, href_fall, vs_rise, vs_fall;
  logic            sample, pix_done, dec_ok, emit;

  // xclk divider free-runs in every state
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      div_cnt_reg <= '0;
      xclk        <= 1'b0;
    end else if (div_cnt_reg == CW'(XCLK_DIV - 1)) begin
      div_cnt_reg <= '0;
      xclk        <= ~xclk;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pclk_sync_reg  <= '0;
      href_sync_reg  <= '0;
      vsync_sync_reg <= '0;
      data_s1_reg    <= '0;
      data_s2_reg    <= '0;
    end else begin
      pclk_sync_reg  <= {pclk_sync_reg[1:0], apclk};
      href_sync_reg  <= {href_sync_reg[1:0], ahref};
      vsync_sync_reg <= {vsync_sync_reg[1:0], avsync};
      data_s1_reg    <= adata;
      data_s2_reg    <= data_s1_reg;
    end
  end

  assign pclk_rise = pclk_sync_reg[1] & ~pclk_sync_reg[2];
  assign href_s    = href_sync_reg[1];
  assign href_fall = ~href_sync_reg[1] & href_sync_reg[2];
  assign vs_rise   = vsync_sync_reg[1] & ~vsync_sync_reg[2];
  assign vs_fall   = ~vsync_sync_reg[1] & vsync_sync_reg[2];

  // First byte of a pixel ends up in the MSBs after BPP shifts
  generate
    if (BPP == 1) begin : g_single_byte
      assign pix_shift = data_s2_reg;
    end else begin : g_multi_byte
      assign pix_shift = {pix_reg[PW-DW-1:0], data_s2_reg};
    end
    if (DEC_LOG2 == 0) begin : g_no_dec
      assign dec_ok = 1'b1;
    end else begin : g_dec
      assign dec_ok = (x_reg[DEC_LOG2-1:0] == '0) && (y_reg[DEC_LOG2-1:0] == '0);
    end
  endgenerate

  assign sample   = pclk_rise & href_s;
  assign pix_done = sample && (byte_cnt_reg == BW'(BPP - 1));
  // A pixel completing on the same cycle as the frame-ending vsync edge is dropped
  assign emit     = pix_done && (state_reg == ACTIVE) && !vs_rise && dec_ok;
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_reg   <= IDLE;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      frame_start <= frame_start_next;
      frame_done  <= frame_done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    frame_start_next = 1'b0;
    frame_done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (capture) state_next = ARMED;
      end
      ARMED: begin
        // In continuous mode a single capture pulse keeps the block armed
        if (!capture && (CONTINUOUS == 0)) begin
          state_next = IDLE;
        end else if (vs_fall) begin
          state_next       = ACTIVE;
          frame_start_next = 1'b1;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          frame_done_next = 1'b1;
          state_next      = ((CONTINUOUS != 0) || capture) ? ARMED : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_en        <= 1'b0;
      wr_data      <= '0;
      wr_addr      <= '0;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_reg      <= '0;
      byte_cnt_reg <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      addr_reg     <= '0;
      line_pix_reg <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (emit) begin
        wr_en   <= 1'b1;
        wr_data <= pix_shift;
        wr_addr <= addr_reg;
        pix_x   <= x_reg;
        pix_y   <= y_reg;
      end
      if (sample) pix_reg <= pix_shift;

      if (frame_start_next) begin
        byte_cnt_reg <= '0;
        x_reg        <= '0;
        y_reg        <= '0;
        addr_reg     <= '0;
        line_pix_reg <= 1'b0;
      end else if (href_fall) begin
        byte_cnt_reg <= '0;
        x_reg        <= '0;
        line_pix_reg <= 1'b0;
        if (line_pix_reg && (y_reg != '1)) y_reg <= y_reg + 1'b1;
      end else if (frame_done_next) begin
        byte_cnt_reg <= '0;
      end else if (sample) begin
        if (pix_done) begin
          byte_cnt_reg <= '0;
          line_pix_reg <= 1'b1;
          if (x_reg != '1) x_reg <= x_reg + 1'b1;
          if (emit) addr_reg <= addr_reg + 1'b1;
        end else begin
          byte_cnt_reg <= byte_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Parametrised camera front-end, successor to the ad-hoc capture logic in the ball-detector top level.
- Generates the sensor master clock and synchronises the asynchronous pclk, href, vsync and data bus into the system clock.
- Assembles multi-byte pixels, counts x/y, applies power-of-two decimation and produces a linear write address and strobe for the frame/line SRAM.
- Arm-on-request state machine; single-shot or continuous capture.

Parameters:
- DW, 8, sensor data bus width
- BPP, 2, bytes per pixel; first byte lands in the MSBs
- XW, 10, width of pix_x counter
- YW, 9, width of pix_y counter
- AW, 12, write address width; address wraps at 2^AW
- XCLK_DIV, 4, clk cycles per xclk half-period (≥1)
- DEC_LOG2, 0, decimation: keep pixels with x and y both multiples of 2^DEC_LOG2
- CONTINUOUS, 0, 1 = re-arm automatically after each frame

Ports:
- clk  in  1  system clock; must be ≥4× pclk
- res  in  1  asynchronous active-high reset
- capture  in  1  level request to arm a frame capture
- apclk  in  1  sensor pixel clock (async)
- ahref  in  1  sensor line-valid (async)
- avsync  in  1  sensor frame sync, high during blanking (async)
- adata  in  DW  sensor data (async)
- xclk  out  1  sensor master clock
- wr_en  out  1  one-cycle pixel write strobe
- wr_data  out  DW*BPP  assembled pixel
- wr_addr  out  AW  linear address of the written pixel
- pix_x  out  XW  x of the written pixel (pre-decimation)
- pix_y  out  YW  y of the written pixel (pre-decimation)
- frame_start  out  1  one-cycle pulse on entering ACTIVE
- frame_done  out  1  one-cycle pulse on frame end
- busy  out  1  high in ARMED or ACTIVE

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; synchronisers cleared.
- xclk: a divider counter counts 0..XCLK_DIV-1; xclk toggles when the counter wraps. The divider free-runs regardless of state.
- Sync: apclk, ahref, avsync and adata each pass through a 2-flop synchroniser. The pclk rising-edge flag is sync2 & ~sync3. vsync rising and falling flags are formed the same way.
- Byte sampling: on a pclk edge with synced href high, the synced adata is shifted into the pixel register.
  - After BPP bytes, the pixel is complete; the byte counter returns to 0.
- Pixel emit: registered; wr_en fires 1 clk after the completing edge flag.
  - Condition: state ACTIVE and low DEC_LOG2 bits of x and y both zero.
  - wr_addr = emitted-pixel count before increment.
  - x increments on every completed pixel, whether emitted or not.
- Line end (synced href falling):
  - byte counter cleared; a partial pixel is discarded;
  - x cleared;
  - y incremented if at least one pixel completed on that line.
- States:
  - IDLE: capture=1 → ARMED.
  - ARMED: vsync falling → ACTIVE. On entry: pulse frame_start; clear x, y, address, byte counter.
  - ACTIVE: vsync rising → frame_done pulse. Then ARMED if CONTINUOUS=1 or capture still high; otherwise IDLE.
- capture deassert during ARMED returns to IDLE; during ACTIVE it is ignored and the frame completes.
- Boundary conditions:
  - vsync rise while href is high ends the frame: partial pixel dropped, no wr_en.
  - Address wrap at 2^AW is silent.
  - x and y saturate at their all-ones values.
  - Pixels with href high outside ACTIVE are never written.
  - Reset mid-frame aborts immediately, with no frame_done.

Test Plan:
- Reset then idle 100 clk → xclk toggles every 4 clk, wr_en never asserted, busy=0.
- capture=1; vsync pulse; 2 lines of 4 pixels, bytes 0x11..0x88 → frame_start once, 8 wr_en, wr_data 0x1122,0x3344…, wr_addr 0..7, y 0/1, frame_done on next vsync rise.
- Line of 7 bytes, BPP=2 → 3 writes, partial byte dropped, next line begins at x=0 with the MSB byte.
- DEC_LOG2=1, 4×4 frame → writes only at (0,0),(2,0),(0,2),(2,2), wr_addr 0..3.
- CONTINUOUS=1, capture pulsed once, 3 frames → three frame_start/frame_done pairs, address restarts at 0 each frame.
- res asserted mid-line → all outputs 0 immediately. After release, capture re-arms and the next frame starts at wr_addr 0.
